// File: rtl/ped_signal.sv
// ped_signal: pedestrian crossing stage driven by traffic-light lamps and a push-button.
module ped_signal #(
    parameter int WALK_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 3,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r,
    input  logic          a,
    input  logic          g,
    input  logic          button,
    output logic          walk,
    output logic          dont_walk,
    output logic          wait_lamp,
    output logic [CW-1:0] countdown,
    output logic          fault
);
    localparam int CLW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] WALK_LOAD = CW'(WALK_CYCLES);
    localparam logic [CLW-1:0] CLEAR_LOAD = CLW'(CLEAR_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, WALK, CLEAR} state_t;

    state_t state, n_state;
    logic pending, n_pending, n_fault, pend_c;
    logic [CW-1:0] n_countdown;
    logic [CLW-1:0] clr_cnt, n_clr_cnt;
    logic red, legal;

    assign red = {r, a, g} == 3'b100;
    assign legal = red || {r, a, g} == 3'b110 || {r, a, g} == 3'b001 || {r, a, g} == 3'b010;
    assign pend_c = pending | button;

    always_comb begin
        n_state = state;
        n_pending = pending;
        n_countdown = countdown;
        n_clr_cnt = clr_cnt;
        n_fault = fault;
        if (!legal) begin
            n_fault = 1'b1;
            n_state = IDLE;
            n_pending = 1'b0;
            n_countdown = '0;
        end else if (!fault) begin
            unique case (state)
                IDLE: begin
                    n_state = button ? WAIT : IDLE;
                    n_pending = button;
                end
                WAIT: if (red) begin
                    n_state = WALK;
                    n_countdown = WALK_LOAD;
                    n_pending = 1'b0;
                end
                WALK: begin
                    n_state = !red ? IDLE : countdown == CW'(1) ? CLEAR : WALK;
                    n_countdown = (!red || countdown == CW'(1)) ? '0 : countdown - CW'(1);
                    n_clr_cnt = CLEAR_LOAD;
                end
                CLEAR: begin
                    // a request made during CLEAR is honoured on the way out
                    n_pending = pend_c;
                    n_state = (!red || clr_cnt == CLW'(1)) ? (pend_c ? WAIT : IDLE) : CLEAR;
                    n_clr_cnt = clr_cnt - CLW'(1);
                end
                default: n_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= 1'b0;
            countdown <= '0;
            clr_cnt <= '0;
            fault <= 1'b0;
            walk <= 1'b0;
            dont_walk <= 1'b1;
            wait_lamp <= 1'b0;
        end else begin
            state <= n_state;
            pending <= n_pending;
            countdown <= n_countdown;
            clr_cnt <= n_clr_cnt;
            fault <= n_fault;
            walk <= n_state == WALK;
            wait_lamp <= n_state == WAIT;
            dont_walk <= n_state == CLEAR ? (state == CLEAR && !dont_walk) : n_state != WALK;
        end
    end
endmodule

// File: tb/tb_ped_signal.sv
// tb_ped_signal: directed vectors with a scoreboard queue popped by an independent monitor.
module tb_ped_signal;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r = 1'b1, a = 1'b0, g = 1'b0, button = 1'b0;
    logic walk, dont_walk, wait_lamp, fault;
    logic [3:0] countdown;

    localparam logic [2:0] RED = 3'b100, RA = 3'b110, GRN = 3'b001, AMB = 3'b010;
    // expected vector: {walk, dont_walk, wait_lamp, fault, countdown}
    localparam logic [7:0] IDL = 8'b0100_0000, WT = 8'b0110_0000, FLT = 8'b0101_0000;
    localparam logic [7:0] CL0 = 8'b0000_0000, CL1 = 8'b0100_0000;

    logic [7:0] exp_q[$];
    int errors = 0, checks = 0, vec = 0;

    ped_signal #(.WALK_CYCLES(4), .CLEAR_CYCLES(3), .CW(4)) dut (
        .clk(clk), .rst(rst), .r(r), .a(a), .g(g), .button(button),
        .walk(walk), .dont_walk(dont_walk), .wait_lamp(wait_lamp),
        .countdown(countdown), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] wk(input int n);
        return {4'b1000, 4'(n)};
    endfunction

    task automatic step(input logic rs, input logic [2:0] lamps, input logic b, input logic [7:0] e);
        @(negedge clk);
        rst = rs;
        {r, a, g} = lamps;
        button = b;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [7:0] e, got;
            e = exp_q.pop_front();
            got = {walk, dont_walk, wait_lamp, fault, countdown};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL vec%0d outputs got=%b required=%b", vec, got, e);
            end
            checks++;
            if (walk && dont_walk) begin
                errors++;
                $display("FAIL vec%0d walk_dw_exclusive got=11 required=not both", vec);
            end
            vec++;
        end
    end

    initial begin
        logic [2:0] cyc [4];
        cyc = '{RED, RA, GRN, AMB};
        // 1: reset then lamps cycling, no button
        step(1, RED, 0, IDL);
        for (int i = 0; i < 40; i++) step(0, cyc[i % 4], 0, IDL);
        // 2: request during GREEN, full crossing with clearance
        step(0, GRN, 1, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, RED, 0, wk(2));
        step(0, RED, 0, wk(1));
        step(0, RED, 0, CL0);
        step(0, RED, 0, CL1);
        step(0, RED, 0, CL0);
        step(0, RED, 0, IDL);
        step(0, RED, 0, IDL);
        step(0, RED, 0, IDL);
        // 3: truncated walk
        step(0, GRN, 1, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, RA, 0, IDL);
        // 4: button during CLEAR re-requests
        step(0, GRN, 1, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, RED, 0, wk(2));
        step(0, RED, 0, wk(1));
        step(0, RED, 0, CL0);
        step(0, RED, 1, CL1);
        step(0, RED, 0, CL0);
        step(0, RED, 0, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, RA, 0, IDL);
        // CLEAR aborted by lamps leaving RED with a pending request
        step(0, GRN, 1, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, RED, 0, wk(2));
        step(0, RED, 0, wk(1));
        step(0, RED, 0, CL0);
        step(0, RED, 1, CL1);
        step(0, RA, 0, WT);
        step(0, GRN, 0, WT);
        step(0, AMB, 0, WT);
        step(0, RED, 0, wk(4));
        step(0, RA, 0, IDL);
        // 5: illegal lamps during WALK, sticky fault
        step(0, GRN, 1, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, 3'b101, 0, FLT);
        step(0, RED, 1, FLT);
        step(0, RED, 0, FLT);
        step(0, GRN, 1, FLT);
        step(1, RED, 0, IDL);
        step(0, RED, 0, IDL);
        step(0, 3'b000, 0, FLT);
        step(1, RED, 0, IDL);
        // 6: reset mid-walk
        step(0, GRN, 1, WT);
        step(0, RED, 0, wk(4));
        step(0, RED, 0, wk(3));
        step(0, RED, 0, wk(2));
        step(1, RED, 0, IDL);
        step(0, RED, 0, IDL);
        step(0, RED, 0, IDL);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
